// File: rtl/key_uart_sched.sv
// key_uart_sched: latches key presses as pending requests and frames them round-robin onto a byte UART.
// Define SCHED_CHKSUM_EN to append a HEADER^idx checksum byte to every frame.
module key_uart_sched #(
  parameter int         KEY_WIDTH = 4,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_flag,
  input  logic [KEY_WIDTH-1:0] key_value,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  output logic [KEY_WIDTH-1:0] pending,
  output logic                 sched_busy,
  output logic [7:0]           ovf_cnt,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ARB       = 4'd1,
    S_SEND_HDR  = 4'd2,
    S_WAIT_HDR  = 4'd3,
    S_SEND_IDX  = 4'd4,
    S_WAIT_IDX  = 4'd5,
    S_FRAME_END = 4'd6
`ifdef SCHED_CHKSUM_EN
    ,
    S_SEND_CHK  = 4'd7,
    S_WAIT_CHK  = 4'd8
`endif
  } state_t;

  state_t               state_r;
  logic [2:0]           rr_ptr_r;
  logic [7:0]           idx_r;
  logic [2:0]           grant_idx_s;
  logic                 found_s;
  int                   dist_s;
  int                   best_dist_s;
  logic [KEY_WIDTH-1:0] grant_oh_s;
  logic [KEY_WIDTH-1:0] set_mask_s;
  logic [KEY_WIDTH-1:0] clr_mask_s;
  logic [KEY_WIDTH-1:0] ovf_bits_s;
  logic [KEY_WIDTH-1:0] pending_nxt_s;
  logic [3:0]           ovf_inc_s;
  logic [8:0]           ovf_sum_s;

  // Round-robin grant: the pending key at the smallest cyclic distance after rr_ptr.
  always_comb begin
    grant_idx_s = 3'd0;
    found_s     = 1'b0;
    best_dist_s = KEY_WIDTH;
    dist_s      = 0;
    for (int j = 0; j < KEY_WIDTH; j++) begin
      dist_s = (j + KEY_WIDTH - 1 - int'(rr_ptr_r)) % KEY_WIDTH;
      if (pending[j] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        grant_idx_s = 3'(j);
        found_s     = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    grant_oh_s = found_s ? (KEY_WIDTH'(1'b1) << grant_idx_s) : '0;
  end

  // Pending update: a fresh press beats the grant clear, and only re-presses of still-pending keys overflow.
  always_comb begin
    set_mask_s    = key_flag ? key_value : '0;
    clr_mask_s    = (state_r == S_ARB) ? grant_oh_s : '0;
    ovf_bits_s    = set_mask_s & pending & ~clr_mask_s;
    pending_nxt_s = (pending & ~clr_mask_s) | set_mask_s;
    ovf_inc_s     = 4'($countones(ovf_bits_s));
    ovf_sum_s     = {1'b0, ovf_cnt} + {5'd0, ovf_inc_s};
  end

  // Frame sequencer with registered UART strobe, data and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      rr_ptr_r   <= 3'(KEY_WIDTH - 1);
      idx_r      <= 8'd0;
      tx_en      <= 1'b0;
      tx_data    <= 8'd0;
      pending    <= '0;
      sched_busy <= 1'b0;
      ovf_cnt    <= 8'd0;
      frame_cnt  <= 16'd0;
    end else begin
      tx_en   <= 1'b0;
      pending <= pending_nxt_s;
      ovf_cnt <= ovf_sum_s[8] ? 8'hFF : ovf_sum_s[7:0];
      case (state_r)
        S_IDLE: begin
          // Looking at this cycle's press too keeps the press-to-strobe latency at three cycles.
          if ((pending | set_mask_s) != '0) begin
            state_r    <= S_ARB;
            sched_busy <= 1'b1;
          end
        end
        S_ARB: begin
          rr_ptr_r <= grant_idx_s;
          idx_r    <= {5'd0, grant_idx_s};
          state_r  <= S_SEND_HDR;
        end
        S_SEND_HDR: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= HEADER;
            state_r <= S_WAIT_HDR;
          end
        end
        S_WAIT_HDR: begin
          if (tx_done) state_r <= S_SEND_IDX;
        end
        S_SEND_IDX: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= idx_r;
            state_r <= S_WAIT_IDX;
          end
        end
        S_WAIT_IDX: begin
`ifdef SCHED_CHKSUM_EN
          if (tx_done) state_r <= S_SEND_CHK;
`else
          if (tx_done) state_r <= S_FRAME_END;
`endif
        end
`ifdef SCHED_CHKSUM_EN
        S_SEND_CHK: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= HEADER ^ idx_r;
            state_r <= S_WAIT_CHK;
          end
        end
        S_WAIT_CHK: begin
          if (tx_done) state_r <= S_FRAME_END;
        end
`endif
        S_FRAME_END: begin
          frame_cnt  <= frame_cnt + 16'd1;
          state_r    <= S_IDLE;
          sched_busy <= 1'b0;
        end
        default: begin
          state_r    <= S_IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
